inst_fetch_unit: RTL and testbench

//  Decoupled instruction fetch stage directly upstream of data_path.
//  - Issues in-order word fetches to instruction memory over a valid/ready request and valid response interface.
//  - Buffers returned words in a small FIFO and presents {inst, inst_pc} to the decode/execute datapath with a valid/ready handshake.
//  - Accepts taken-branch redirects from the datapath and squashes stale fetches.

---
 rtl/inst_fetch_unit.sv | 167 ++++++++++++++++
 tb/tb_inst_fetch_unit.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : inst_fetch_unit
//  Description : Decoupled in-order instruction fetch with credit-limited
//                requests, a small output FIFO and branch-redirect squashing.
//                Optional IFU_MISALIGN_CHECK_EN enables sticky misaligned-
//                redirect fault detection.
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch_unit #(
   parameter int             N        = 32,
   parameter int             DEPTH    = 2,
   parameter logic [N-1:0]   RESET_PC = '0
) (
   input  logic          clk,
   input  logic          reset,
   output logic          imem_req_valid,
   output logic [N-1:0]  imem_req_addr,
   input  logic          imem_req_ready,
   input  logic          imem_rsp_valid,
   input  logic [N-1:0]  imem_rsp_data,
   input  logic          redirect,
   input  logic [N-1:0]  redirect_pc,
   output logic          inst_valid,
   output logic [N-1:0]  inst,
   output logic [N-1:0]  inst_pc,
   input  logic          inst_ready,
   output logic          fetch_fault
);

   localparam int                 c_CNT_W = $clog2(DEPTH + 1);
   localparam int                 c_SUM_W = c_CNT_W + 1;
   localparam int                 c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [c_SUM_W-1:0] c_DEPTH = c_SUM_W'(DEPTH);
   localparam logic [c_PTR_W-1:0] c_LAST  = c_PTR_W'(DEPTH - 1);
   localparam logic [N-1:0]       c_NOP   = N'(32'h0000_0013);
   localparam logic [N-1:0]       c_STEP  = N'(4);

   logic [N-1:0]         r_fetch_pc;
   logic [N-1:0]         r_rsp_pc;
   logic [c_CNT_W-1:0]   r_outstanding;
   logic [c_CNT_W-1:0]   r_drop_cnt;
   logic [c_CNT_W-1:0]   r_count;
   logic [c_PTR_W-1:0]   r_head;
   logic [c_PTR_W-1:0]   r_tail;
   logic [N-1:0]         r_fifo_inst [DEPTH];
   logic [N-1:0]         r_fifo_pc   [DEPTH];

   logic                 w_accept;
   logic                 w_rsp_ok;
   logic                 w_drop;
   logic                 w_push;
   logic                 w_pop;
   logic                 w_credit_ok;
   logic                 w_fault;
   logic [N-1:0]         w_target;
   logic [c_CNT_W-1:0]   w_outstanding_nxt;
   logic [c_CNT_W-1:0]   w_count_nxt;

   function automatic logic [c_PTR_W-1:0] f_ptr_inc(input logic [c_PTR_W-1:0] p);
      return (p == c_LAST) ? '0 : p + 1'b1;
   endfunction

`ifdef IFU_MISALIGN_CHECK_EN
   logic r_fault;
   logic w_misalign;

   assign w_target   = redirect_pc;
   assign w_misalign = redirect && (redirect_pc[1:0] != 2'b00);
   assign w_fault    = r_fault;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_fault <= 1'b0;
      end else if (w_misalign) begin
         r_fault <= 1'b1;
      end
   end
`else
   logic w_unused_lsb;

   assign w_unused_lsb = ^redirect_pc[1:0];
   assign w_target     = {redirect_pc[N-1:2], 2'b00};
   assign w_fault      = 1'b0;
`endif

   // Credits count both in-flight and buffered words, so a response always finds room.
   assign w_credit_ok    = ({1'b0, r_outstanding} + {1'b0, r_count}) < c_DEPTH;
   assign imem_req_valid = !reset && !redirect && !w_fault && w_credit_ok;
   assign imem_req_addr  = r_fetch_pc;

   assign w_accept = imem_req_valid && imem_req_ready;
   assign w_rsp_ok = imem_rsp_valid && (r_outstanding != '0);
   assign w_drop   = w_rsp_ok && (r_drop_cnt != '0);
   assign w_push   = w_rsp_ok && !w_drop && !redirect;
   assign w_pop    = inst_valid && inst_ready;

   assign inst_valid  = (r_count != '0);
   assign inst        = inst_valid ? r_fifo_inst[r_head] : c_NOP;
   assign inst_pc     = inst_valid ? r_fifo_pc[r_head]   : '0;
   assign fetch_fault = w_fault;

   always_comb begin
      w_outstanding_nxt = r_outstanding;
      if (w_accept && !w_rsp_ok) begin
         w_outstanding_nxt = r_outstanding + 1'b1;
      end else if (!w_accept && w_rsp_ok) begin
         w_outstanding_nxt = r_outstanding - 1'b1;
      end
   end

   always_comb begin
      w_count_nxt = r_count;
      if (w_push && !w_pop) begin
         w_count_nxt = r_count + 1'b1;
      end else if (!w_push && w_pop) begin
         w_count_nxt = r_count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_fetch_pc    <= RESET_PC;
         r_rsp_pc      <= RESET_PC;
         r_outstanding <= '0;
         r_drop_cnt    <= '0;
         r_count       <= '0;
         r_head        <= '0;
         r_tail        <= '0;
      end else begin
         r_outstanding <= w_outstanding_nxt;
         if (redirect) begin
            // Everything still in flight after this cycle belongs to the old path.
            r_fetch_pc <= w_target;
            r_rsp_pc   <= w_target;
            r_drop_cnt <= w_outstanding_nxt;
            r_count    <= '0;
            r_head     <= '0;
            r_tail     <= '0;
         end else begin
            if (w_accept) begin
               r_fetch_pc <= r_fetch_pc + c_STEP;
            end
            if (w_drop) begin
               r_drop_cnt <= r_drop_cnt - 1'b1;
            end
            if (w_push) begin
               r_rsp_pc <= r_rsp_pc + c_STEP;
               r_tail   <= f_ptr_inc(r_tail);
            end
            if (w_pop) begin
               r_head <= f_ptr_inc(r_head);
            end
            r_count <= w_count_nxt;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo_inst[r_tail] <= imem_rsp_data;
         r_fifo_pc[r_tail]   <= r_rsp_pc;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_inst_fetch_unit
//  Description : Scoreboard bench for inst_fetch_unit with a behavioural
//                memory and fetch-stream reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_fetch_unit;

   localparam int          c_N        = 32;
   localparam logic [31:0] c_RESET_PC = 32'h0;
   localparam logic [31:0] c_NOP      = 32'h0000_0013;

   logic          clk;
   logic          reset;
   logic          imem_req_valid;
   logic [31:0]   imem_req_addr;
   logic          imem_req_ready;
   logic          imem_rsp_valid;
   logic [31:0]   imem_rsp_data;
   logic          redirect;
   logic [31:0]   redirect_pc;
   logic          inst_valid;
   logic [31:0]   inst;
   logic [31:0]   inst_pc;
   logic          inst_ready;
   logic          fetch_fault;

   inst_fetch_unit #(.N(c_N), .DEPTH(2), .RESET_PC(c_RESET_PC)) dut (
      .clk            (clk),
      .reset          (reset),
      .imem_req_valid (imem_req_valid),
      .imem_req_addr  (imem_req_addr),
      .imem_req_ready (imem_req_ready),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect       (redirect),
      .redirect_pc    (redirect_pc),
      .inst_valid     (inst_valid),
      .inst           (inst),
      .inst_pc        (inst_pc),
      .inst_ready     (inst_ready),
      .fetch_fault    (fetch_fault)
   );

   typedef struct {
      int          due;
      logic [31:0] addr;
   } rsp_t;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          n_accepts = 0;
   int          lat_min = 1;
   int          lat_max = 1;
   logic [63:0] exp_q [$];
   rsp_t        mem_q [$];
   logic [31:0] model_pc = c_RESET_PC;
   logic        exp_fault = 1'b0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1);
   end

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h0001_0003) ^ 32'h5A5A_A5A5;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%h required=%h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Memory model plus expected-stream producer: every accepted request pushes
   // the word the datapath must eventually see; a redirect or reset voids them.
   initial begin : env
      logic        s_reset, s_redir, s_acc, s_rv;
      logic [31:0] s_tgt, s_addr;
      int          last_due, due;
      rsp_t        r;
      last_due       = 0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      forever begin
         @(negedge clk);
         s_reset = reset;
         s_redir = redirect;
         s_tgt   = redirect_pc;
         s_rv    = imem_req_valid;
         s_acc   = imem_req_valid && imem_req_ready;
         s_addr  = imem_req_addr;
         @(posedge clk);
         cyc++;
         if (s_reset) begin
            exp_q.delete();
            mem_q.delete();
            model_pc  = c_RESET_PC;
            exp_fault = 1'b0;
            last_due  = cyc;
         end else if (s_redir) begin
            check("redirect_blocks_req", {31'b0, s_rv}, 32'h0);
            exp_q.delete();
`ifdef IFU_MISALIGN_CHECK_EN
            if (s_tgt[1:0] != 2'b00) exp_fault = 1'b1;
            model_pc = s_tgt;
`else
            model_pc = s_tgt & 32'hFFFF_FFFC;
`endif
         end else if (s_acc) begin
            n_accepts++;
            if (exp_fault) check("req_after_fault", 32'h1, 32'h0);
            check("req_addr", s_addr, model_pc);
            exp_q.push_back({mem_word(model_pc), model_pc});
            model_pc = model_pc + 32'd4;
            due = cyc + $urandom_range(lat_max, lat_min) - 1;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            r.due  = due;
            r.addr = s_addr;
            mem_q.push_back(r);
         end
         #1;
         if (!s_reset && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            r = mem_q.pop_front();
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(r.addr);
         end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
         end
      end
   end

   always @(negedge clk) begin : monitor
      logic [63:0] e;
      if (!reset) begin
         check("fetch_fault", {31'b0, fetch_fault}, {31'b0, exp_fault});
         if (inst_valid && inst_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_inst_pc", inst_pc, 32'hxxxx_xxxx);
            end else begin
               e = exp_q.pop_front();
               check("inst_pc", inst_pc, e[31:0]);
               check("inst", inst, e[63:32]);
            end
         end else if (!inst_valid) begin
            check("empty_inst_nop", inst, c_NOP);
            check("empty_inst_pc", inst_pc, 32'h0);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      redirect = 1'b0;
      @(negedge clk);
      check("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
      @(posedge clk);
      @(negedge clk);
      check("rst_inst_valid", {31'b0, inst_valid}, 32'h0);
      check("rst_inst", inst, c_NOP);
      check("rst_inst_pc", inst_pc, 32'h0);
      check("rst_fetch_fault", {31'b0, fetch_fault}, 32'h0);
      check("rst_req_valid_q", {31'b0, imem_req_valid}, 32'h0);
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   // Returns at a negedge; found reports whether inst_valid was seen in budget.
   task automatic wait_inst(output bit found);
      found = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (inst_valid) begin
            found = 1'b1;
            break;
         end
      end
   endtask

   initial begin : driver
      logic [31:0] iv [3];
      logic [31:0] pc2;
      int          base;
      bit          found;
      reset          = 1'b1;
      redirect       = 1'b0;
      redirect_pc    = '0;
      imem_req_ready = 1'b1;
      inst_ready     = 1'b1;
      step();

      // 1: first-fetch latency with a 1-cycle memory
      lat_min = 1; lat_max = 1;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         iv[i] = {31'b0, inst_valid};
         if (i == 2) pc2 = inst_pc;
      end
      check("lat_c0_valid", iv[0], 32'h0);
      check("lat_c1_valid", iv[1], 32'h0);
      check("lat_c2_valid", iv[2], 32'h1);
      check("lat_c2_pc", pc2, c_RESET_PC);
      step();
      repeat (20) step();

      // 2: consumer stalled -> exactly DEPTH requests accepted
      inst_ready = 1'b0;
      do_reset();
      base = n_accepts;
      repeat (10) step();
      @(negedge clk);
      check("stall_accepts", n_accepts - base, 32'd2);
      check("stall_req_valid", {31'b0, imem_req_valid}, 32'h0);
      check("stall_inst_valid", {31'b0, inst_valid}, 32'h1);
      check("stall_inst_pc", inst_pc, 32'h0);
      check("stall_inst", inst, mem_word(32'h0));
      step();
      inst_ready = 1'b1;
      repeat (10) step();

      // 3: 3-cycle memory, redirect with two fetches in flight
      lat_min = 3; lat_max = 3;
      do_reset();
      base = n_accepts;
      step();
      step();
      check("inflight_accepts", n_accepts - base, 32'd2);
      redirect = 1'b1; redirect_pc = 32'h100;
      step();
      redirect = 1'b0;
      wait_inst(found);
      check("redir_found", {31'b0, found}, 32'h1);
      check("redir_first_pc", inst_pc, 32'h100);
      step();
      repeat (15) step();

      // 4: memory not ready -> request held with stable address
      lat_min = 1; lat_max = 1;
      imem_req_ready = 1'b0;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("hold_valid", {31'b0, imem_req_valid}, 32'h1);
         check("hold_addr", imem_req_addr, c_RESET_PC);
      end
      step();
      imem_req_ready = 1'b1;
      base = n_accepts;
      step();
      check("first_ready_accept", n_accepts - base, 32'd1);
      repeat (10) step();

      // 5: redirect coinciding with a pop and a returning response
      found = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk);
         #2;
         if (inst_valid && imem_rsp_valid) begin
            found = 1'b1;
            break;
         end
      end
      check("pop_rsp_cycle_found", {31'b0, found}, 32'h1);
      redirect = 1'b1; redirect_pc = 32'h200;
      @(posedge clk);
      #1;
      redirect = 1'b0;
      @(negedge clk);
      check("flush_empty", {31'b0, inst_valid}, 32'h0);
      step();
      wait_inst(found);
      check("after_flush_pc", inst_pc, 32'h200);
      step();
      repeat (10) step();

      // 6: misaligned redirect
      redirect = 1'b1; redirect_pc = 32'h102;
      step();
      redirect = 1'b0;
`ifdef IFU_MISALIGN_CHECK_EN
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("fault_sticky", {31'b0, fetch_fault}, 32'h1);
         check("fault_req_low", {31'b0, imem_req_valid}, 32'h0);
      end
      step();
`else
      wait_inst(found);
      check("misalign_found", {31'b0, found}, 32'h1);
      check("misalign_forced_pc", inst_pc, 32'h100);
      step();
`endif

      // Randomised traffic, redirects (incl. address wrap) and occasional resets
      lat_min = 1; lat_max = 4;
      do_reset();
      for (int i = 0; i < 1500; i++) begin
         inst_ready     = ($urandom_range(3, 0) != 0);
         imem_req_ready = ($urandom_range(2, 0) != 0);
         redirect       = ($urandom_range(24, 0) == 0);
         reset          = ($urandom_range(399, 0) == 0);
         if (i == 700) begin
            redirect    = 1'b1;
            redirect_pc = 32'hFFFF_FFF8;
         end else begin
`ifdef IFU_MISALIGN_CHECK_EN
            redirect_pc = $urandom & 32'hFFFF_FFFC;
`else
            redirect_pc = $urandom;
`endif
         end
         step();
      end

      // Drain everything still owed to the datapath
      reset          = 1'b0;
      redirect       = 1'b0;
      inst_ready     = 1'b1;
      imem_req_ready = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && mem_q.size() == 0) break;
      end
      check("drain_outstanding", exp_q.size(), 32'd0);
      @(negedge clk);
      check("drain_inst_valid", {31'b0, inst_valid}, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
